draw_sprite_blit: RTL and testbench

DRAW_SPRITE_BLIT -- requirements
Module: draw_sprite_blit

---
 rtl/draw_sprite_blit.sv | 213 +++++++++++++++++++++
 tb/tb_draw_sprite_blit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite_blit.sv
// draw_sprite_blit: copies one SPR_W x SPR_H sprite from image memory into a
// frame buffer. It supports horizontal/vertical mirroring, clipping at the
// frame edges and a transparency colour key.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             draw request, sampled only while idle
//   x_in, y_in        sprite top-left position in the frame
//   sprite_id         sprite index in image memory
//   flip_h, flip_v    mirror modes
//   key_en, key_color transparency colour key
//   img_mem_addr      image memory read address (data returns one cycle later)
//   img_pixel_data    image memory read data
//   frame_addr/_data  frame buffer write address / data
//   frame_we          frame buffer write enable
//   busy              high while a draw is in progress
//   rdy               one-cycle pulse when a draw completes
//
// Timing: the pixel fetched in cycle k is written in cycle k+1. frame_we and
// frame_data follow img_pixel_data combinationally so that the write lands in
// the same cycle the memory data arrives.
module draw_sprite_blit #(
  parameter int unsigned FRAME_W = 320,
  parameter int unsigned FRAME_H = 240,
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_H   = 16,
  parameter int unsigned ID_W    = 6,
  parameter int unsigned PIX_W   = 24
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [8:0]                             x_in,
  input  logic [7:0]                             y_in,
  input  logic [ID_W-1:0]                        sprite_id,
  input  logic                                   flip_h,
  input  logic                                   flip_v,
  input  logic                                   key_en,
  input  logic [PIX_W-1:0]                       key_color,
  output logic [ID_W+$clog2(SPR_W*SPR_H)-1:0]    img_mem_addr,
  input  logic [PIX_W-1:0]                       img_pixel_data,
  output logic [16:0]                            frame_addr,
  output logic [PIX_W-1:0]                       frame_data,
  output logic                                   frame_we,
  output logic                                   busy,
  output logic                                   rdy
);

  localparam int unsigned COL_W  = $clog2(SPR_W);
  localparam int unsigned ROW_W  = $clog2(SPR_H);
  localparam int unsigned AW     = ID_W + ROW_W + COL_W;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned PROD_W = 20;
  localparam int unsigned FA_W   = 17;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [8:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               fh_q, fh_d;
  logic               fv_q, fv_d;
  logic               key_en_q, key_en_d;
  logic [PIX_W-1:0]   key_q, key_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [FA_W-1:0]    fa_q, fa_d;
  logic               wr_vld_q, wr_vld_d;
  logic               in_frame_q, in_frame_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;

  // Mirrored source address; power-of-two sprite sizes make N-1-i equal to ~i.
  function automatic logic [AW-1:0] src_addr(input logic [ID_W-1:0]  id,
                                             input logic             fh,
                                             input logic             fv,
                                             input logic [ROW_W-1:0] row,
                                             input logic [COL_W-1:0] col);
    logic [ROW_W-1:0] srow;
    logic [COL_W-1:0] scol;
    srow = fv ? ~row : row;
    scol = fh ? ~col : col;
    return {id, srow, scol};
  endfunction

  // Destination of the pixel currently on the fetch address; sums are 10 bits
  // wide so positions past the frame edge cannot wrap back inside it.
  logic [SUM_W-1:0]  dx_c, dy_c;
  logic [PROD_W-1:0] lin_c;
  logic              in_frame_c;
  logic              last_c;

  assign dx_c       = SUM_W'(x_q) + SUM_W'(col_q);
  assign dy_c       = SUM_W'(y_q) + SUM_W'(row_q);
  assign lin_c      = PROD_W'(dy_c) * PROD_W'(FRAME_W) + PROD_W'(dx_c);
  assign in_frame_c = (32'(dx_c) < FRAME_W) && (32'(dy_c) < FRAME_H);
  assign last_c     = (row_q == ROW_W'(SPR_H - 1)) && (col_q == COL_W'(SPR_W - 1));

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      fh_q       <= 1'b0;
      fv_q       <= 1'b0;
      key_en_q   <= 1'b0;
      key_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mem_addr_q <= '0;
      fa_q       <= '0;
      wr_vld_q   <= 1'b0;
      in_frame_q <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      fh_q       <= fh_d;
      fv_q       <= fv_d;
      key_en_q   <= key_en_d;
      key_q      <= key_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mem_addr_q <= mem_addr_d;
      fa_q       <= fa_d;
      wr_vld_q   <= wr_vld_d;
      in_frame_q <= in_frame_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    id_d       = id_q;
    fh_d       = fh_q;
    fv_d       = fv_q;
    key_en_d   = key_en_q;
    key_d      = key_q;
    row_d      = row_q;
    col_d      = col_q;
    mem_addr_d = '0;
    fa_d       = '0;
    wr_vld_d   = 1'b0;
    in_frame_d = 1'b0;
    rdy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          x_d      = x_in;
          y_d      = y_in;
          id_d     = sprite_id;
          fh_d     = flip_h;
          fv_d     = flip_v;
          key_en_d = key_en;
          key_d    = key_color;
          row_d    = '0;
          col_d    = '0;
        end
      end
      FETCH: begin
        // Queue the write for the pixel fetched this cycle.
        fa_d       = FA_W'(lin_c);
        in_frame_d = in_frame_c;
        wr_vld_d   = 1'b1;
        if (last_c) begin
          state_d = FLUSH;
        end else begin
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(SPR_W - 1)) begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Fetch address for the next cycle, built from the values being latched.
    if (state_d == FETCH) begin
      mem_addr_d = src_addr(id_d, fh_d, fv_d, row_d, col_d);
    end

    busy_d = (state_d != IDLE);
  end

  assign img_mem_addr = mem_addr_q;
  assign frame_addr   = fa_q;
  assign busy         = busy_q;
  assign rdy          = rdy_q;

  // Write qualifiers: clipped and colour-keyed pixels still take their slot.
  assign frame_we   = wr_vld_q & in_frame_q & ~(key_en_q & (img_pixel_data == key_q));
  assign frame_data = wr_vld_q ? img_pixel_data : '0;

endmodule

// File: tb/tb_draw_sprite_blit.sv
// Testbench for draw_sprite_blit: directed table, back-to-back and reset
// sequences, and randomized draws checked against a pixel-level model.
module tb_draw_sprite_blit;

  localparam int CAPN    = 260;
  localparam int RDY_CYC = 258;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [5:0]  sprite_id = '0;
  logic        flip_h = 1'b0;
  logic        flip_v = 1'b0;
  logic        key_en = 1'b0;
  logic [23:0] key_color = '0;
  logic [13:0] img_mem_addr;
  logic [23:0] img_pixel_data = '0;
  logic [16:0] frame_addr;
  logic [23:0] frame_data;
  logic        frame_we;
  logic        busy;
  logic        rdy;

  always #5 clk = ~clk;

  draw_sprite_blit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .x_in           (x_in),
    .y_in           (y_in),
    .sprite_id      (sprite_id),
    .flip_h         (flip_h),
    .flip_v         (flip_v),
    .key_en         (key_en),
    .key_color      (key_color),
    .img_mem_addr   (img_mem_addr),
    .img_pixel_data (img_pixel_data),
    .frame_addr     (frame_addr),
    .frame_data     (frame_data),
    .frame_we       (frame_we),
    .busy           (busy),
    .rdy            (rdy)
  );

  // Image memory: synchronous read, one cycle latency.
  logic [23:0] mem [0:16383];
  logic [23:0] palette [0:7];
  logic        use_mem = 1'b0;

  always @(posedge clk) img_pixel_data <= use_mem ? mem[img_mem_addr] : 24'hAABBCC;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [5:0]  id;
    logic        fh;
    logic        fv;
    logic        ke;
    logic [23:0] kc;
  } vec_t;

  typedef struct {
    vec_t v;
    int   n;
    int   ffa;
    int   lfa;
    int   m0;
    int   m1;
    int   mlast;
  } row_t;

  int total = 0;
  int bad   = 0;

  logic [13:0] cap_maddr [0:CAPN];
  logic        cap_we    [0:CAPN];
  logic [16:0] cap_fa    [0:CAPN];
  logic [23:0] cap_fd    [0:CAPN];
  logic        cap_busy  [0:CAPN];
  logic        cap_rdy   [0:CAPN];

  int          exp_maddr [0:255];
  logic        exp_we    [0:255];
  int          exp_fa    [0:255];
  logic [23:0] exp_fd    [0:255];

  task automatic chk(input string name, input longint got, input longint req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  function automatic vec_t mkv(input int x, input int y, input int id, input logic fh,
                               input logic fv, input logic ke, input logic [23:0] kc);
    vec_t v;
    v.x  = 9'(x);
    v.y  = 8'(y);
    v.id = 6'(id);
    v.fh = fh;
    v.fv = fv;
    v.ke = ke;
    v.kc = kc;
    return v;
  endfunction

  function automatic row_t mk(input vec_t v, input int n, input int ffa, input int lfa,
                              input int m0, input int m1, input int ml);
    row_t r;
    r.v = v; r.n = n; r.ffa = ffa; r.lfa = lfa; r.m0 = m0; r.m1 = m1; r.mlast = ml;
    return r;
  endfunction

  // Reference: every sprite pixel in raster order, with its source, target and write decision.
  task automatic model(input vec_t v);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int i, sr, sc, src, xx, yy;
        logic [23:0] d;
        i   = r * 16 + c;
        sr  = v.fv ? 15 - r : r;
        sc  = v.fh ? 15 - c : c;
        src = int'(v.id) * 256 + sr * 16 + sc;
        d   = use_mem ? mem[src] : 24'hAABBCC;
        xx  = int'(v.x) + c;
        yy  = int'(v.y) + r;
        exp_maddr[i] = src;
        exp_fd[i]    = d;
        exp_fa[i]    = yy * 320 + xx;
        exp_we[i]    = (xx < 320) && (yy < 240) && !(v.ke && d == v.kc);
      end
    end
  endtask

  // Called just after a falling edge; start is sampled at the next rising edge (edge 0).
  task automatic launch(input vec_t v);
    x_in = v.x; y_in = v.y; sprite_id = v.id;
    flip_h = v.fh; flip_v = v.fv; key_en = v.ke; key_color = v.kc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    x_in      = 9'($urandom);
    y_in      = 8'($urandom);
    sprite_id = 6'($urandom);
    flip_h    = 1'($urandom);
    flip_v    = 1'($urandom);
    key_en    = 1'($urandom);
    key_color = 24'($urandom);
  endtask

  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_maddr[c] = img_mem_addr;
      cap_we[c]    = frame_we;
      cap_fa[c]    = frame_addr;
      cap_fd[c]    = frame_data;
      cap_busy[c]  = busy;
      cap_rdy[c]   = rdy;
    end
  endtask

  task automatic check_draw(input vec_t v, input int n, input string tag,
                            output int nw, output int ffa, output int lfa);
    int mism, firstbad, rdyn, busyerr, expn;
    model(v);
    mism = 0; firstbad = -1; rdyn = 0; busyerr = 0; expn = 0; nw = 0; ffa = -1; lfa = -1;
    for (int i = 0; i < 256; i++) begin
      if (int'(cap_maddr[i + 1]) != exp_maddr[i]) begin
        mism++;
        if (firstbad < 0) firstbad = i + 1;
      end
      if (cap_we[i + 2] != exp_we[i] ||
          (exp_we[i] && (int'(cap_fa[i + 2]) != exp_fa[i] || cap_fd[i + 2] != exp_fd[i]))) begin
        mism++;
        if (firstbad < 0) firstbad = i + 2;
      end
      if (exp_we[i]) expn++;
    end
    if (cap_we[1] || cap_we[RDY_CYC]) mism++;
    if (mism != 0)
      $display("FAIL %s_stream: got %0d mismatching cycles (first at cycle %0d) required 0",
               tag, mism, firstbad);
    total++;
    if (mism != 0) bad++;
    for (int c = 1; c <= n; c++) begin
      if (cap_rdy[c]) rdyn++;
      if (cap_busy[c] != (c <= RDY_CYC - 1)) busyerr++;
      if (cap_we[c]) begin
        nw++;
        if (ffa < 0) ffa = int'(cap_fa[c]);
        lfa = int'(cap_fa[c]);
      end
    end
    chk({tag, "_rdy_count"}, rdyn, 1);
    chk({tag, "_rdy_at_258"}, cap_rdy[RDY_CYC], 1);
    chk({tag, "_busy_profile_errs"}, busyerr, 0);
    chk({tag, "_nwrites_vs_model"}, nw, expn);
  endtask

  initial begin
    row_t rows [0:5];
    int   nw, ffa, lfa;
    int   busy_low, seen;
    logic [13:0] m60;

    rows[0] = mk(mkv(0, 0, 0, 0, 0, 0, 24'h000000),   256, 0,     4815,  0,   1,   255);
    rows[1] = mk(mkv(0, 0, 1, 1, 1, 0, 24'h000000),   256, 0,     4815,  511, 510, 256);
    rows[2] = mk(mkv(312, 232, 0, 0, 0, 0, 24'h0),    64,  74552, 76799, 0,   1,   255);
    rows[3] = mk(mkv(0, 0, 0, 0, 0, 1, 24'hAABBCC),   0,   -1,    -1,    0,   1,   255);
    rows[4] = mk(mkv(0, 0, 0, 0, 0, 1, 24'h000000),   256, 0,     4815,  0,   1,   255);
    rows[5] = mk(mkv(100, 50, 2, 1, 0, 0, 24'h0),     256, 16100, 20915, 527, 526, 752);

    // Reset held with random inputs: every output stays 0.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom); x_in = 9'($urandom); y_in = 8'($urandom);
      sprite_id = 6'($urandom); flip_h = 1'($urandom); flip_v = 1'($urandom);
      key_en = 1'($urandom); key_color = 24'($urandom);
      @(negedge clk);
      chk($sformatf("reset_outputs_%0d", k),
          {busy, rdy, frame_we, |img_mem_addr, |frame_addr, |frame_data}, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || frame_we || rdy) seen++;
    end
    chk("idle_after_release", seen, 0);

    // Directed table.
    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      launch(rows[r].v);
      capture(CAPN);
      check_draw(rows[r].v, CAPN, tag, nw, ffa, lfa);
      chk({tag, "_nwrites"}, nw, rows[r].n);
      chk({tag, "_first_fa"}, ffa, rows[r].ffa);
      chk({tag, "_last_fa"}, lfa, rows[r].lfa);
      chk({tag, "_maddr_first"}, cap_maddr[1], rows[r].m0);
      chk({tag, "_maddr_second"}, cap_maddr[2], rows[r].m1);
      chk({tag, "_maddr_last"}, cap_maddr[256], rows[r].mlast);
    end

    // Start accepted in the rdy cycle.
    launch(rows[0].v);
    capture(RDY_CYC);
    check_draw(rows[0].v, RDY_CYC, "b2b_first", nw, ffa, lfa);
    launch(rows[1].v);
    capture(CAPN);
    chk("b2b_busy_next_cycle", cap_busy[1], 1);
    check_draw(rows[1].v, CAPN, "b2b_second", nw, ffa, lfa);

    // Start while busy is ignored; reset mid-draw aborts.
    launch(rows[0].v);
    busy_low = 0;
    m60 = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (c == 60) m60 = img_mem_addr;
      if (c == 50) begin
        start = 1'b1; sprite_id = 6'd5; flip_h = 1'b1; flip_v = 1'b1; x_in = 9'd200;
      end
      if (c == 51) start = 1'b0;
    end
    chk("busy_start_busy_low", busy_low, 0);
    chk("busy_start_maddr_c60", m60, 59);
    chk("pre_reset_we", frame_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, rdy, frame_we, |img_mem_addr, |frame_addr, |frame_data}, 0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy || rdy || frame_we) seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || rdy || frame_we) seen++;
    end
    chk("abort_no_activity", seen, 0);
    launch(rows[0].v);
    capture(CAPN);
    check_draw(rows[0].v, CAPN, "after_abort", nw, ffa, lfa);
    chk("after_abort_nwrites", nw, 256);

    // Randomized draws over a small palette so the colour key hits often.
    for (int k = 0; k < 8; k++) palette[k] = 24'($urandom);
    for (int i = 0; i < 16384; i++) mem[i] = palette[$urandom_range(0, 7)];
    use_mem = 1'b1;
    for (int t = 0; t < 8; t++) begin
      vec_t v;
      v.x  = (t % 2 == 0) ? 9'($urandom_range(290, 511)) : 9'($urandom);
      v.y  = (t % 3 == 0) ? 8'($urandom_range(220, 255)) : 8'($urandom);
      v.id = 6'($urandom);
      v.fh = 1'($urandom);
      v.fv = 1'($urandom);
      v.ke = 1'($urandom);
      v.kc = palette[$urandom_range(0, 7)];
      launch(v);
      capture(CAPN);
      check_draw(v, CAPN, $sformatf("rand%0d", t), nw, ffa, lfa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
